spram_arb_ctrl: RTL and testbench

- Sequencer/arbiter that shares one single-port SRAM (generic_spram, RAM_LATENCY-cycle read) between two requesters, e.g. L1D lookup (port 0) and refill/writeback (port 1).
- Performs round-robin arbitration with a valid/ready handshake and returns read data on a per-port response channel after a fixed latency.
- Optionally zero-sweeps the array after reset.
- Drives the SRAM pins directly. The SRAM is instantiated alongside it in the integrating wrapper.

---
 rtl/spram_arb_ctrl_if.sv | 51 +++++
 rtl/spram_arb_ctrl.sv | 145 ++++++++++++++
 tb/tb_spram_arb_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/spram_arb_ctrl_if.sv
// Request/response channels and SRAM pin bundle for spram_arb_ctrl.
// slave = controller side, master = requesters plus the SRAM data return.
interface spram_arb_ctrl_if #(
    parameter int W     = 64,
    parameter int P     = 8,
    parameter int LOG2D = 6
);
    localparam int BE = W / P;

    logic             req0_valid;
    logic             req0_ready;
    logic             req0_we;
    logic [BE-1:0]    req0_biten;
    logic [LOG2D-1:0] req0_addr;
    logic [W-1:0]     req0_wdata;
    logic             req1_valid;
    logic             req1_ready;
    logic             req1_we;
    logic [BE-1:0]    req1_biten;
    logic [LOG2D-1:0] req1_addr;
    logic [W-1:0]     req1_wdata;
    logic             resp0_valid;
    logic [W-1:0]     resp0_rdata;
    logic             resp1_valid;
    logic [W-1:0]     resp1_rdata;
    logic             init_done;
    logic             sram_ce;
    logic             sram_we;
    logic [BE-1:0]    sram_biten;
    logic [LOG2D-1:0] sram_addr;
    logic [W-1:0]     sram_din;
    logic [W-1:0]     sram_dout;

    modport slave (
        input  req0_valid, req0_we, req0_biten, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_biten, req1_addr, req1_wdata,
        input  sram_dout,
        output req0_ready, req1_ready, resp0_valid, resp0_rdata,
        output resp1_valid, resp1_rdata, init_done,
        output sram_ce, sram_we, sram_biten, sram_addr, sram_din
    );

    modport master (
        output req0_valid, req0_we, req0_biten, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_biten, req1_addr, req1_wdata,
        output sram_dout,
        input  req0_ready, req1_ready, resp0_valid, resp0_rdata,
        input  resp1_valid, resp1_rdata, init_done,
        input  sram_ce, sram_we, sram_biten, sram_addr, sram_din
    );
endinterface

// File: rtl/spram_arb_ctrl.sv
// Two-port round-robin sequencer in front of one single-port SRAM with fixed read latency.
// Define SPRAM_ARB_INIT_EN to zero-sweep the whole array after every reset.
module spram_arb_ctrl #(
    parameter int W           = 64,
    parameter int P           = 8,
    parameter int D           = 64,
    parameter int LOG2D       = 6,
    parameter int RAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rstn,
    spram_arb_ctrl_if.slave   bus
);
    localparam int BE = W / P;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

`ifdef SPRAM_ARB_INIT_EN
    localparam state_t RST_STATE = ST_INIT;
    localparam logic   RST_DONE  = 1'b0;
`else
    localparam state_t RST_STATE = ST_RUN;
    localparam logic   RST_DONE  = 1'b1;
`endif

    state_t                 r_state;
    logic                   r_rr_ptr;
    logic                   r_init_done;
    logic [LOG2D-1:0]       r_init_addr;
    logic [RAM_LATENCY-1:0] r_pipe_v;
    logic [RAM_LATENCY-1:0] r_pipe_id;

    logic             w_run, w_both, w_grant0, w_grant1, w_hs0, w_hs1, w_rd_push;
    logic             w_ce, w_we;
    logic [BE-1:0]    w_biten;
    logic [LOG2D-1:0] w_addr;
    logic [W-1:0]     w_din;

    // Grant decode; rstn gating keeps ready/ce low while reset is asserted
    always_comb begin
        w_run  = rstn & (r_state == ST_RUN);
        w_both = bus.req0_valid & bus.req1_valid;
        if (w_both) begin
            w_grant0 = ~r_rr_ptr;
            w_grant1 = r_rr_ptr;
        end else begin
            w_grant0 = bus.req0_valid;
            w_grant1 = bus.req1_valid;
        end
        w_hs0     = w_run & w_grant0;
        w_hs1     = w_run & w_grant1;
        w_rd_push = (w_hs0 & ~bus.req0_we) | (w_hs1 & ~bus.req1_we);
    end

    // SRAM pin mux: init sweep, port 0 winner, port 1 winner, or idle
    always_comb begin
        w_ce    = 1'b0;
        w_we    = 1'b0;
        w_biten = {BE{1'b0}};
        w_addr  = {LOG2D{1'b0}};
        w_din   = {W{1'b0}};
        if (rstn && (r_state == ST_INIT)) begin
            w_ce    = 1'b1;
            w_we    = 1'b1;
            w_biten = {BE{1'b1}};
            w_addr  = r_init_addr;
        end else if (w_hs0) begin
            w_ce    = 1'b1;
            w_we    = bus.req0_we;
            w_biten = bus.req0_biten;
            w_addr  = bus.req0_addr;
            w_din   = bus.req0_wdata;
        end else if (w_hs1) begin
            w_ce    = 1'b1;
            w_we    = bus.req1_we;
            w_biten = bus.req1_biten;
            w_addr  = bus.req1_addr;
            w_din   = bus.req1_wdata;
        end else begin
            w_ce    = 1'b0;
        end
    end

    // Control FSM: init sweep counter, run state, round-robin pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= RST_STATE;
            r_rr_ptr    <= 1'b0;
            r_init_done <= RST_DONE;
            r_init_addr <= {LOG2D{1'b0}};
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_done <= 1'b0;
                    if (r_init_addr == LOG2D'(D - 1)) begin
                        r_init_addr <= {LOG2D{1'b0}};
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_init_addr <= r_init_addr + {{(LOG2D-1){1'b0}}, 1'b1};
                    end
                end
                ST_RUN: begin
                    r_init_done <= 1'b1;
                    if (w_both) begin
                        r_rr_ptr <= ~r_rr_ptr;
                    end else begin
                        r_rr_ptr <= r_rr_ptr;
                    end
                end
                default: begin
                    r_state <= RST_STATE;
                end
            endcase
        end
    end

    // Read-latency pipe carrying {valid, port id}; reset drops in-flight reads
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pipe_v  <= {RAM_LATENCY{1'b0}};
            r_pipe_id <= {RAM_LATENCY{1'b0}};
        end else begin
            r_pipe_v[0]  <= w_rd_push;
            r_pipe_id[0] <= w_hs1;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                r_pipe_v[i]  <= r_pipe_v[i-1];
                r_pipe_id[i] <= r_pipe_id[i-1];
            end
        end
    end

    assign bus.req0_ready  = w_hs0;
    assign bus.req1_ready  = w_hs1;
    assign bus.init_done   = r_init_done;
    assign bus.sram_ce     = w_ce;
    assign bus.sram_we     = w_we;
    assign bus.sram_biten  = w_biten;
    assign bus.sram_addr   = w_addr;
    assign bus.sram_din    = w_din;
    assign bus.resp0_valid = r_pipe_v[RAM_LATENCY-1] & ~r_pipe_id[RAM_LATENCY-1];
    assign bus.resp1_valid = r_pipe_v[RAM_LATENCY-1] &  r_pipe_id[RAM_LATENCY-1];
    assign bus.resp0_rdata = bus.resp0_valid ? bus.sram_dout : {W{1'b0}};
    assign bus.resp1_rdata = bus.resp1_valid ? bus.sram_dout : {W{1'b0}};
endmodule

// File: tb/tb_spram_arb_ctrl.sv
// Bench for spram_arb_ctrl: directed steps plus random traffic against a
// scheduled-response scoreboard and a shadow memory.
module tb_spram_arb_ctrl;
    localparam int W = 64, P = 8, D = 64, LOG2D = 6, L = 1;
    localparam int BE = W / P;
`ifdef SPRAM_ARB_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    spram_arb_ctrl_if #(.W(W), .P(P), .LOG2D(LOG2D)) bus ();

    spram_arb_ctrl #(.W(W), .P(P), .D(D), .LOG2D(LOG2D), .RAM_LATENCY(L)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Behavioural SRAM: byte-enabled writes, L-cycle read pipe
    logic [W-1:0] mem [D];
    logic [W-1:0] rd_pipe [L];
    always @(posedge clk) begin
        if (bus.sram_ce && bus.sram_we) begin
            for (int b = 0; b < BE; b++)
                if (bus.sram_biten[b]) mem[bus.sram_addr][b*P +: P] <= bus.sram_din[b*P +: P];
        end else if (bus.sram_ce) begin
            rd_pipe[0] <= mem[bus.sram_addr];
        end
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.sram_dout = rd_pipe[L-1];

    // Reference model state
    typedef struct { int due; bit port; logic [W-1:0] data; } rsp_t;
    rsp_t         q[$];
    logic [W-1:0] ref_mem [D];
    bit           m_rr;
    int           m_init_left;
    int           cyc;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set0(input bit v, input bit we, input int a, input logic [W-1:0] d, input logic [BE-1:0] be);
        bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = LOG2D'(a);
        bus.req0_wdata = d; bus.req0_biten = be;
    endtask

    task automatic set1(input bit v, input bit we, input int a, input logic [W-1:0] d, input logic [BE-1:0] be);
        bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = LOG2D'(a);
        bus.req1_wdata = d; bus.req1_biten = be;
    endtask

    task automatic model_reset();
        q.delete();
        m_rr = 1'b0;
        m_init_left = INIT_EN ? D : 0;
        if (INIT_EN) for (int i = 0; i < D; i++) ref_mem[i] = '0;
    endtask

    // One clock cycle: check against the model, advance the model, move to next negedge
    task automatic cycle();
        bit e0, e1, port, er0, er1, we;
        int a;
        logic [W-1:0] d, ed;
        logic [BE-1:0] be;
        rsp_t r;
        #1;
        if (m_init_left > 0) begin
            chk("init_ready0", 64'(bus.req0_ready), 64'd0);
            chk("init_ready1", 64'(bus.req1_ready), 64'd0);
            chk("init_ce", 64'(bus.sram_ce), 64'd1);
            chk("init_we", 64'(bus.sram_we), 64'd1);
            chk("init_addr", 64'(bus.sram_addr), 64'(D - m_init_left));
            chk("init_done_low", 64'(bus.init_done), 64'd0);
            m_init_left--;
        end else begin
            chk("init_done", 64'(bus.init_done), 64'd1);
            e0 = bus.req0_valid && (!bus.req1_valid || m_rr == 1'b0);
            e1 = bus.req1_valid && (!bus.req0_valid || m_rr == 1'b1);
            chk("ready0", 64'(bus.req0_ready), 64'(e0));
            chk("ready1", 64'(bus.req1_ready), 64'(e1));
            chk("sram_ce", 64'(bus.sram_ce), 64'(e0 | e1));
            if (e0 || e1) begin
                port = e1;
                we = port ? bus.req1_we : bus.req0_we;
                a  = port ? int'(bus.req1_addr) : int'(bus.req0_addr);
                d  = port ? bus.req1_wdata : bus.req0_wdata;
                be = port ? bus.req1_biten : bus.req0_biten;
                chk("sram_we", 64'(bus.sram_we), 64'(we));
                chk("sram_addr", 64'(bus.sram_addr), 64'(a));
                if (we) begin
                    chk("sram_din", bus.sram_din, d);
                    chk("sram_biten", 64'(bus.sram_biten), 64'(be));
                    for (int b = 0; b < BE; b++) if (be[b]) ref_mem[a][b*P +: P] = d[b*P +: P];
                end else begin
                    r.due = cyc + L; r.port = port; r.data = ref_mem[a];
                    q.push_back(r);
                end
            end
            if (bus.req0_valid && bus.req1_valid) m_rr = ~m_rr;
        end
        er0 = 1'b0; er1 = 1'b0; ed = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            if (r.port) er1 = 1'b1; else er0 = 1'b1;
            ed = r.data;
        end
        chk("resp0_valid", 64'(bus.resp0_valid), 64'(er0));
        chk("resp1_valid", 64'(bus.resp1_valid), 64'(er1));
        chk("resp0_rdata", bus.resp0_rdata, er0 ? ed : 64'd0);
        chk("resp1_rdata", bus.resp1_rdata, er1 ? ed : 64'd0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0;
        for (int i = 0; i < D; i++) ref_mem[i] = 'x;
        set0(1'b1, 1'b0, 5, '0, '0);
        set1(1'b1, 1'b0, 6, '0, '0);
        model_reset();
        // Reset: outputs held at reset values even with both requesters valid
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready0", 64'(bus.req0_ready), 64'd0);
        chk("rst_ready1", 64'(bus.req1_ready), 64'd0);
        chk("rst_ce", 64'(bus.sram_ce), 64'd0);
        chk("rst_we", 64'(bus.sram_we), 64'd0);
        chk("rst_resp0", 64'(bus.resp0_valid), 64'd0);
        chk("rst_resp1", 64'(bus.resp1_valid), 64'd0);
        chk("rst_rdata0", bus.resp0_rdata, 64'd0);
        chk("rst_init_done", 64'(bus.init_done), INIT_EN ? 64'd0 : 64'd1);
        set1(1'b0, 1'b0, 0, '0, '0);
        if (!INIT_EN) set0(1'b0, 1'b0, 0, '0, '0);
        @(negedge clk);
        rstn = 1'b1;

        if (INIT_EN) begin
            // req0 read of addr 5 held through the sweep, accepted at cycle D
            repeat (D + 1) cycle();
            set0(1'b0, 1'b0, 0, '0, '0);
        end else begin
            // Preload every entry through port 0 so the shadow memory is fully known
            for (int i = 0; i < D; i++) begin
                set0(1'b1, 1'b1, i, {$urandom, $urandom}, 8'hFF);
                cycle();
            end
            set0(1'b0, 1'b0, 0, '0, '0);
        end
        repeat (L + 1) cycle();

        // Write then read-after-write on port 0
        set0(1'b1, 1'b1, 3, 64'h0000_0000_DEAD_BEEF, 8'hFF); cycle();
        set0(1'b1, 1'b0, 3, '0, '0);                         cycle();
        set0(1'b0, 1'b0, 0, '0, '0);
        repeat (L + 1) cycle();

        // Contested reads for 4 cycles from rr_ptr = 0
        set0(1'b1, 1'b0, 10, '0, '0);
        set1(1'b1, 1'b0, 11, '0, '0);
        repeat (4) cycle();
        // Only req1 for 3 cycles; pointer must stay put
        set0(1'b0, 1'b0, 0, '0, '0);
        repeat (3) cycle();
        set0(1'b1, 1'b0, 12, '0, '0);
        cycle();
        set0(1'b0, 1'b0, 0, '0, '0);
        set1(1'b0, 1'b0, 0, '0, '0);
        repeat (L + 1) cycle();

        // Partial byte enables and an all-zero byte-enable write
        set1(1'b1, 1'b1, 7, {W{1'b1}}, 8'hFF); cycle();
        set1(1'b1, 1'b1, 7, '0, 8'h0F);        cycle();
        set1(1'b1, 1'b0, 7, '0, '0);           cycle();
        set1(1'b1, 1'b1, 7, 64'h1234, 8'h00);  cycle();
        set1(1'b1, 1'b0, 7, '0, '0);           cycle();
        set1(1'b0, 1'b0, 0, '0, '0);
        repeat (L + 1) cycle();

        // Random traffic on both ports
        for (int n = 0; n < 300; n++) begin
            set0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, D - 1)),
                 {$urandom, $urandom}, 8'($urandom));
            set1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, D - 1)),
                 {$urandom, $urandom}, 8'($urandom));
            cycle();
        end
        set0(1'b0, 1'b0, 0, '0, '0);
        set1(1'b0, 1'b0, 0, '0, '0);
        repeat (L + 2) cycle();

        // Read accepted, then reset before its data returns
        set0(1'b1, 1'b0, 9, '0, '0);
        #1;
        chk("mr_ready0", 64'(bus.req0_ready), 64'd1);
        #1;
        rstn = 1'b0;
        #1;
        chk("mr_ready0_rst", 64'(bus.req0_ready), 64'd0);
        chk("mr_ce_rst", 64'(bus.sram_ce), 64'd0);
        chk("mr_resp0_rst", 64'(bus.resp0_valid), 64'd0);
        chk("mr_init_done", 64'(bus.init_done), INIT_EN ? 64'd0 : 64'd1);
        set0(1'b0, 1'b0, 0, '0, '0);
        repeat (2) begin
            @(posedge clk); @(negedge clk); #1;
            chk("mr_no_resp0", 64'(bus.resp0_valid), 64'd0);
            chk("mr_no_resp1", 64'(bus.resp1_valid), 64'd0);
        end
        rstn = 1'b1;
        model_reset();
        while (m_init_left > 0) cycle();
        set0(1'b1, 1'b0, 7, '0, '0); cycle();
        set0(1'b0, 1'b0, 0, '0, '0);
        repeat (L + 1) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
